// File: rtl/l1_line_ctrl_if.sv
// Signal bundle for one L1 line slot: CPU access, peek, refill and writeback.
// The design connects to slave; the driver of the slot (controller or bench) connects to master.
interface l1_line_ctrl_if #(
  parameter int TAG_W   = 23,
  parameter int SET_W   = 4,
  parameter int WORD_AW = 3
);
  logic              rreq, wreq;
  logic [31:0]       addr, wdata;
  logic [3:0]        wstrb;
  logic              hit;
  logic [31:0]       rdata;
  logic [31:0]       peek_addr;
  logic              peek_hit;
  logic [31:0]       peek_rdata;
  logic              fill_start;
  logic [TAG_W-1:0]  fill_tag;
  logic [SET_W-1:0]  fill_set;
  logic              fill_valid;
  logic [31:0]       fill_data;
  logic              evict_req;
  logic              wb_valid, wb_ready;
  logic [31:0]       wb_addr, wb_data;
  logic              evict_done;
  logic              line_valid, line_dirty, busy;

  modport slave (
    input  rreq, wreq, addr, wdata, wstrb, peek_addr,
           fill_start, fill_tag, fill_set, fill_valid, fill_data,
           evict_req, wb_ready,
    output hit, rdata, peek_hit, peek_rdata, wb_valid, wb_addr, wb_data,
           evict_done, line_valid, line_dirty, busy
  );

  modport master (
    output rreq, wreq, addr, wdata, wstrb, peek_addr,
           fill_start, fill_tag, fill_set, fill_valid, fill_data,
           evict_req, wb_ready,
    input  hit, rdata, peek_hit, peek_rdata, wb_valid, wb_addr, wb_data,
           evict_done, line_valid, line_dirty, busy
  );
endinterface

// File: rtl/l1_line_ctrl.sv
// One L1 cache line: tag/set, valid/dirty state, burst refill, dirty writeback,
// zero-latency CPU hit path and a side-effect-free peek port.
module l1_line_ctrl #(
  parameter int TAG_W   = 23,
  parameter int SET_W   = 4,
  parameter int WORD_AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  l1_line_ctrl_if.slave bus
);
  localparam int WORDS = 2**WORD_AW;
  localparam logic [WORD_AW-1:0] LAST = WORD_AW'(WORDS-1);

  if (TAG_W + SET_W + WORD_AW + 2 != 32) begin : g_bad_split
    $error("l1_line_ctrl: TAG_W+SET_W+WORD_AW+2 must equal 32");
  end

  typedef enum logic [2:0] {S_INV, S_FILL, S_CLEAN, S_DIRTY, S_WB} state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [WORD_AW-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [31:0]        mem_q [WORDS];

  logic               mem_we;
  logic [WORD_AW-1:0] mem_widx;
  logic [31:0]        mem_wval, merged;

  logic [TAG_W-1:0]   a_tag, p_tag;
  logic [SET_W-1:0]   a_set, p_set;
  logic [WORD_AW-1:0] a_word, p_word;
  logic               match, p_match, readable;
  logic               unused_lsbs;

  assign a_tag  = bus.addr[31 -: TAG_W];
  assign a_set  = bus.addr[31-TAG_W -: SET_W];
  assign a_word = bus.addr[2 +: WORD_AW];
  assign p_tag  = bus.peek_addr[31 -: TAG_W];
  assign p_set  = bus.peek_addr[31-TAG_W -: SET_W];
  assign p_word = bus.peek_addr[2 +: WORD_AW];
  assign unused_lsbs = ^{bus.addr[1:0], bus.peek_addr[1:0]};

  assign readable = (state_q == S_CLEAN) || (state_q == S_DIRTY);
  assign match    = (a_tag == tag_q) && (a_set == set_q);
  assign p_match  = (p_tag == tag_q) && (p_set == set_q);

  // Eviction wins over a same-cycle CPU access, so the hit is suppressed outright.
  assign bus.hit        = readable && (bus.rreq || bus.wreq) && match && !bus.evict_req;
  assign bus.rdata      = (bus.hit && bus.rreq) ? mem_q[a_word] : 32'h0;
  assign bus.peek_hit   = readable && p_match;
  assign bus.peek_rdata = bus.peek_hit ? mem_q[p_word] : 32'h0;
  assign bus.wb_valid   = (state_q == S_WB);
  assign bus.wb_addr    = bus.wb_valid ? {tag_q, set_q, cnt_q, 2'b00} : 32'h0;
  assign bus.wb_data    = bus.wb_valid ? mem_q[cnt_q] : 32'h0;
  assign bus.evict_done = done_q;
  assign bus.line_valid = readable;
  assign bus.line_dirty = (state_q == S_DIRTY);
  assign bus.busy       = (state_q == S_FILL) || (state_q == S_WB);

  always_comb begin
    merged = mem_q[a_word];
    for (int b = 0; b < 4; b++)
      if (bus.wstrb[b]) merged[8*b +: 8] = bus.wdata[8*b +: 8];
  end

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    set_d    = set_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    mem_widx = cnt_q;
    mem_wval = bus.fill_data;
    case (state_q)
      S_INV: if (bus.fill_start) begin
        state_d = S_FILL;
        tag_d   = bus.fill_tag;
        set_d   = bus.fill_set;
        cnt_d   = '0;
      end
      S_FILL: if (bus.evict_req) begin
        state_d = S_INV;
        done_d  = 1'b1;
      end else if (bus.fill_valid) begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_CLEAN;
      end
      S_CLEAN, S_DIRTY: if (bus.evict_req) begin
        if (state_q == S_CLEAN) begin
          state_d = S_INV;
          done_d  = 1'b1;
        end else begin
          state_d = S_WB;
          cnt_d   = '0;
        end
      end else if (bus.hit && bus.wreq) begin
        // An all-zero strobe still counts as a write and dirties the line.
        mem_we   = 1'b1;
        mem_widx = a_word;
        mem_wval = merged;
        state_d  = S_DIRTY;
      end
      S_WB: if (bus.wb_ready) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_INV;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_INV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INV;
      tag_q   <= '0;
      set_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Line storage carries no reset; it is only observable once a fill completes.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_widx] <= mem_wval;
  end
endmodule

// File: tb/tb_l1_line_ctrl.sv
// Directed bench for l1_line_ctrl: refill, hit read/write, writeback, eviction, reset abort.
module tb_l1_line_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  l1_line_ctrl_if #(.TAG_W(23), .SET_W(4), .WORD_AW(3)) bus ();
  l1_line_ctrl #(.TAG_W(23), .SET_W(4), .WORD_AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [22:0] t, input logic [3:0] s, input logic [2:0] w);
    return {t, s, w, 2'b00};
  endfunction

  // Start a fill and stream 8 words base+i; optional bubble before every odd word.
  task automatic fill_line(input logic [22:0] t, input logic [3:0] s, input logic [31:0] base,
                           input bit bub);
    bus.fill_start = 1'b1; bus.fill_tag = t; bus.fill_set = s;
    tick();
    bus.fill_start = 1'b0;
    #1 chk("fill_busy", {31'b0, bus.busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (bub && (i % 2 == 1)) begin
        bus.fill_valid = 1'b0;
        tick();
      end
      bus.fill_valid = 1'b1;
      bus.fill_data  = base + i;
      if (i == 7) begin
        bus.peek_addr = mk(t, s, 3'd0);
        #1;
        chk("fill_not_valid", {31'b0, bus.line_valid}, 32'd0);
        chk("fill_peek_zero", {31'b0, bus.peek_hit}, 32'd0);
      end
      tick();
    end
    bus.fill_valid = 1'b0;
  endtask

  logic [31:0] exp_wb [8];
  int beat, ncyc, n_done;
  bit rdy;

  initial begin
    bus.rreq = 0; bus.wreq = 0; bus.addr = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.peek_addr = 0; bus.fill_start = 0; bus.fill_tag = 0; bus.fill_set = 0;
    bus.fill_valid = 0; bus.fill_data = 0; bus.evict_req = 0; bus.wb_ready = 0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state
    bus.rreq = 1'b1; bus.addr = mk(23'h1234, 4'd5, 3'd7);
    #1;
    chk("rst_hit",   {31'b0, bus.hit}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_valid", {31'b0, bus.line_valid}, 32'd0);
    chk("rst_wb",    {31'b0, bus.wb_valid}, 32'd0);
    chk("rst_busy",  {31'b0, bus.busy}, 32'd0);
    bus.rreq = 1'b0;

    // 2: bubbled refill, then hit reads
    fill_line(23'h1234, 4'd5, 32'hA0, 1'b1);
    chk("fill_clean", {30'b0, bus.line_valid, bus.line_dirty}, 32'd2);
    chk("fill_idle",  {31'b0, bus.busy}, 32'd0);
    bus.rreq = 1'b1; bus.addr = mk(23'h1234, 4'd5, 3'd7);
    #1;
    chk("rd7_hit",   {31'b0, bus.hit}, 32'd1);
    chk("rd7_data",  bus.rdata, 32'hA7);
    bus.addr = mk(23'h1234, 4'd5, 3'd0);
    #1 chk("rd0_data", bus.rdata, 32'hA0);
    bus.addr = mk(23'h1234, 4'd6, 3'd0);
    #1;
    chk("miss_hit",  {31'b0, bus.hit}, 32'd0);
    chk("miss_data", bus.rdata, 32'd0);
    bus.rreq = 1'b0;
    bus.peek_addr = mk(23'h1234, 4'd5, 3'd3);
    #1;
    chk("peek_hit",  {31'b0, bus.peek_hit}, 32'd1);
    chk("peek_data", bus.peek_rdata, 32'hA3);
    bus.peek_addr = mk(23'h1235, 4'd5, 3'd3);
    #1 chk("peek_miss", bus.peek_rdata, 32'd0);
    // fill_start while CLEAN is ignored
    bus.fill_start = 1'b1; bus.fill_tag = 23'h77; bus.fill_set = 4'd1;
    tick();
    bus.fill_start = 1'b0;
    bus.rreq = 1'b1; bus.addr = mk(23'h1234, 4'd5, 3'd1);
    #1 chk("ign_fill", bus.rdata, 32'hA1);
    bus.rreq = 1'b0;

    // 3: partial write dirties the line
    bus.wreq = 1'b1; bus.addr = mk(23'h1234, 4'd5, 3'd2);
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'b0011;
    #1 chk("wr_hit", {31'b0, bus.hit}, 32'd1);
    tick();
    bus.wreq = 1'b0; bus.rreq = 1'b1;
    #1;
    chk("wr_merge", bus.rdata, 32'h0000BEEF);
    chk("wr_dirty", {31'b0, bus.line_dirty}, 32'd1);
    bus.rreq = 1'b0;

    // 4: writeback with wb_ready toggling
    for (int i = 0; i < 8; i++) exp_wb[i] = 32'hA0 + i;
    exp_wb[2] = 32'h0000BEEF;
    bus.evict_req = 1'b1;
    tick();
    bus.evict_req = 1'b0;
    bus.rreq = 1'b1; bus.addr = mk(23'h1234, 4'd5, 3'd0);
    #1 chk("wb_nohit", {31'b0, bus.hit}, 32'd0);
    bus.rreq = 1'b0;
    beat = 0; ncyc = 0; n_done = 0; rdy = 1'b1;
    while (beat < 8 && ncyc < 40) begin
      bus.wb_ready = rdy;
      #1;
      chk("wb_valid", {31'b0, bus.wb_valid}, 32'd1);
      chk("wb_addr",  bus.wb_addr, mk(23'h1234, 4'd5, beat[2:0]));
      chk("wb_data",  bus.wb_data, exp_wb[beat]);
      if (bus.evict_done) n_done++;
      if (rdy) beat++;
      tick();
      rdy = ~rdy;
      ncyc++;
    end
    chk("wb_beats", beat, 32'd8);
    bus.wb_ready = 1'b0;
    #1;
    if (bus.evict_done) n_done++;
    chk("wb_inval", {31'b0, bus.line_valid}, 32'd0);
    chk("wb_idle",  {31'b0, bus.busy}, 32'd0);
    tick();
    chk("wb_pulse", n_done, 32'd1);
    chk("wb_pulse_end", {31'b0, bus.evict_done}, 32'd0);
    // evict on an invalid line does nothing
    bus.evict_req = 1'b1;
    tick();
    bus.evict_req = 1'b0;
    chk("inv_evict", {31'b0, bus.evict_done}, 32'd0);

    // 5: evict + write same cycle on a clean line
    fill_line(23'h0055, 4'hA, 32'h100, 1'b0);
    bus.evict_req = 1'b1; bus.wreq = 1'b1; bus.addr = mk(23'h0055, 4'hA, 3'd4);
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
    #1 chk("ev_wr_hit", {31'b0, bus.hit}, 32'd0);
    tick();
    bus.evict_req = 1'b0; bus.wreq = 1'b0;
    #1;
    chk("ev_done",  {31'b0, bus.evict_done}, 32'd1);
    chk("ev_inval", {31'b0, bus.line_valid}, 32'd0);
    tick();
    chk("ev_done_end", {31'b0, bus.evict_done}, 32'd0);
    // refill same line: word 4 must hold refill data, a zero-strobe write only dirties
    fill_line(23'h0055, 4'hA, 32'h200, 1'b0);
    bus.wreq = 1'b1; bus.addr = mk(23'h0055, 4'hA, 3'd4); bus.wstrb = 4'h0;
    #1 chk("z_hit", {31'b0, bus.hit}, 32'd1);
    tick();
    bus.wreq = 1'b0; bus.rreq = 1'b1;
    #1;
    chk("z_data",  bus.rdata, 32'h204);
    chk("z_dirty", {31'b0, bus.line_dirty}, 32'd1);
    bus.rreq = 1'b0;

    // 6: reset mid-fill abandons the burst
    reset = 1'b1; tick(); reset = 1'b0;
    bus.fill_start = 1'b1; bus.fill_tag = 23'h0042; bus.fill_set = 4'd3;
    tick();
    bus.fill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.fill_valid = 1'b1; bus.fill_data = 32'h300 + i;
      tick();
    end
    bus.fill_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rf_busy", {31'b0, bus.busy}, 32'd0);
    chk("rf_done", {31'b0, bus.evict_done}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      bus.fill_valid = 1'b1; bus.fill_data = 32'h400 + i;
      tick();
    end
    bus.fill_valid = 1'b0;
    chk("rf_ignored", {30'b0, bus.line_valid, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
